instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writer side of the instruction store that the instruction counter reads.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses starting from 0, for a programmed number of words.
- Signals completion so the core can release reset and start counting from address 0.

Parameters:
- ADDR_W, 5, instruction memory word-address width; the store depth is 2^ADDR_W words.
- LEN_W, ADDR_W+1, width of the word-count input.

Ports:
- il_clk  input  1  clock
- il_rst_n  input  1  asynchronous active-low reset
- il_start  input  1  one-cycle pulse; begins a load when idle
- il_abort  input  1  synchronous abort; returns to IDLE
- il_len  input  LEN_W  number of words to load; sampled on start
- il_byte  input  8  stream byte
- il_byte_valid  input  1  il_byte is valid
- il_byte_ready  output  1  loader accepts a byte this cycle
- il_we  output  1  instruction memory write strobe
- il_waddr  output  ADDR_W  memory word address
- il_wdata  output  32  memory write data
- il_busy  output  1  load in progress
- il_done  output  1  last load completed normally; held until the next start
- il_err  output  1  checksum mismatch; held until the next start
- il_count  output  LEN_W  words written in the current or last load

Behaviour:
- Reset (async, il_rst_n=0): state IDLE; all outputs 0; byte-lane index 0; address 0; word buffer 0.
- States: IDLE, ASSEMBLE, WRITE, CHECK, DONE.
- IDLE:
  - il_start=1 and il_len=0: go to DONE. No writes; il_count=0.
  - il_start=1 and il_len>0: latch the effective length; clear il_done, il_err, il_count and address; go to ASSEMBLE.
  - Effective length is il_len, saturated to 2^ADDR_W if larger.
- ASSEMBLE:
  - il_byte_ready=1.
  - A byte is accepted on il_byte_valid && il_byte_ready.
  - Byte k (k=0..3) is stored in word bits [8k+7:8k].
  - After the 4th accepted byte, go to WRITE.
  - Byte-to-WRITE latency: 1 cycle.
- WRITE:
  - Exactly one cycle with il_we=1, il_waddr=current address, il_wdata=assembled word; il_byte_ready=0.
  - On exit, increment the address and il_count.
  - If il_count+1 equals the effective length, go to CHECK when ILOAD_CHECKSUM_EN is defined, otherwise DONE.
  - Otherwise go to ASSEMBLE with lane 0.
- DONE: il_done=1 for one cycle in this state, then IDLE. il_done stays 1 in IDLE until the next il_start.
- il_busy=1 in ASSEMBLE, WRITE and CHECK only.
- il_start while busy: ignored.
- il_abort: highest priority below reset; from any state go to IDLE next cycle.
  - il_done and il_err are not set.
  - il_count keeps the number of words already written.
  - No il_we in the abort cycle.
  - A partial word is discarded.
- Address: never wraps within a load, because the length saturates at depth; starts at 0 on every start.
- Byte offered while il_byte_ready=0: not consumed; the source must hold it.

Optional Feature:
- Macro ILOAD_CHECKSUM_EN.
- Defined:
  - Running 8-bit XOR of every accepted data byte, cleared on start.
  - CHECK state raises il_byte_ready=1 and accepts one extra byte.
  - If that byte differs from the XOR, set il_err=1; go to DONE either way.
  - A zero-length load skips CHECK.
- Not defined: no CHECK state, no XOR register; il_err tied to 0.

Test Plan:
- Reset mid-load: start il_len=3, drop il_rst_n after 5 bytes -> all outputs 0 immediately; il_we never asserted afterwards.
- Single word: il_len=1, bytes 13,00,00,00 back-to-back -> one cycle il_we, il_waddr=0, il_wdata=0x00000013 one cycle after the 4th byte; then il_done=1, il_count=1, il_busy=0.
- Back-pressure and gaps: il_len=2, valid toggled every other cycle -> exactly 2 writes, addr 0 then 1; no byte accepted during WRITE cycles.
- Saturation/zero length: il_len=40 with 128 bytes -> 32 writes, addrs 0..31, il_count=32. il_len=0 -> il_done next cycle, no writes.
- Abort: il_len=4, abort after 6 bytes -> one write only (addr 0); IDLE; il_done=0, il_count=1; a new start writes again from addr 0.
- ILOAD_CHECKSUM_EN: il_len=1, bytes 01,02,04,08 then checksum 0F -> il_err=0, il_done=1. Checksum 0E -> il_err=1, il_done=1.

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional ILOAD_CHECKSUM_EN adds a trailing XOR checksum byte that is checked against the stream.
module instruction_loader #(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              il_clk,
    input  logic              il_rst_n,
    input  logic              il_start,
    input  logic              il_abort,
    input  logic [LEN_W-1:0]  il_len,
    input  logic [7:0]        il_byte,
    input  logic              il_byte_valid,
    output logic              il_byte_ready,
    output logic              il_we,
    output logic [ADDR_W-1:0] il_waddr,
    output logic [31:0]       il_wdata,
    output logic              il_busy,
    output logic              il_done,
    output logic              il_err,
    output logic [LEN_W-1:0]  il_count
);
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
`ifdef ILOAD_CHECKSUM_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t state, next;
    logic [1:0] lane;
    logic [LEN_W-1:0] eff_len;
    logic take, last;

    assign take = il_byte_valid && il_byte_ready;
    assign last = LEN_W'(il_count + 1'b1) == eff_len;

    always_ff @(posedge il_clk or negedge il_rst_n) begin
        if (!il_rst_n) state <= IDLE;
        else           state <= next;
    end

    always_comb begin
        next          = state;
        il_byte_ready = 1'b0;
        il_we         = 1'b0;
        il_busy       = 1'b0;
        case (state)
            IDLE: if (il_start) next = (il_len == '0) ? DONE : ASSEMBLE;
            ASSEMBLE: begin
                il_busy       = 1'b1;
                il_byte_ready = 1'b1;
                if (il_byte_valid && lane == 2'd3) next = WRITE;
            end
            WRITE: begin
                il_busy = 1'b1;
                il_we   = 1'b1;
`ifdef ILOAD_CHECKSUM_EN
                next = last ? CHECK : ASSEMBLE;
`else
                next = last ? DONE : ASSEMBLE;
`endif
            end
`ifdef ILOAD_CHECKSUM_EN
            CHECK: begin
                il_busy       = 1'b1;
                il_byte_ready = 1'b1;
                if (il_byte_valid) next = DONE;
            end
`endif
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
        // abort overrides everything: nothing consumed, nothing written
        if (il_abort) begin
            next          = IDLE;
            il_byte_ready = 1'b0;
            il_we         = 1'b0;
        end
    end

`ifdef ILOAD_CHECKSUM_EN
    logic [7:0] xsum;
    always_ff @(posedge il_clk or negedge il_rst_n) begin
        if (!il_rst_n) begin
            xsum   <= '0;
            il_err <= 1'b0;
        end else if (state == IDLE && il_start && !il_abort) begin
            xsum   <= '0;
            il_err <= 1'b0;
        end else if (take && state == ASSEMBLE) begin
            xsum <= xsum ^ il_byte;
        end else if (take && state == CHECK) begin
            il_err <= il_byte != xsum;
        end
    end
`else
    assign il_err = 1'b0;
`endif

    always_ff @(posedge il_clk or negedge il_rst_n) begin
        if (!il_rst_n) begin
            lane     <= '0;
            il_waddr <= '0;
            il_wdata <= '0;
            eff_len  <= '0;
            il_count <= '0;
            il_done  <= 1'b0;
        end else if (il_abort) begin
            lane <= '0;
        end else begin
            case (state)
                IDLE: if (il_start) begin
                    eff_len  <= (il_len > DEPTH) ? DEPTH : il_len;
                    il_count <= '0;
                    il_waddr <= '0;
                    lane     <= '0;
                    il_done  <= 1'b0;
                end
                ASSEMBLE: if (take) begin
                    il_wdata[{lane, 3'b000} +: 8] <= il_byte;
                    lane <= lane + 1'b1;
                end
                WRITE: begin
                    il_waddr <= il_waddr + 1'b1;
                    il_count <= il_count + 1'b1;
                end
                default: ;
            endcase
            if (next == DONE) il_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: randomized loads checked against a word-level model of the byte stream.
module tb_instruction_loader;
    localparam int ADDR_W = 5;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              il_clk = 1'b0;
    logic              il_rst_n = 1'b0;
    logic              il_start = 1'b0;
    logic              il_abort = 1'b0;
    logic [LEN_W-1:0]  il_len = '0;
    logic [7:0]        il_byte = '0;
    logic              il_byte_valid = 1'b0;
    logic              il_byte_ready;
    logic              il_we;
    logic [ADDR_W-1:0] il_waddr;
    logic [31:0]       il_wdata;
    logic              il_busy;
    logic              il_done;
    logic              il_err;
    logic [LEN_W-1:0]  il_count;

    instruction_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .il_clk(il_clk), .il_rst_n(il_rst_n), .il_start(il_start), .il_abort(il_abort),
        .il_len(il_len), .il_byte(il_byte), .il_byte_valid(il_byte_valid),
        .il_byte_ready(il_byte_ready), .il_we(il_we), .il_waddr(il_waddr),
        .il_wdata(il_wdata), .il_busy(il_busy), .il_done(il_done), .il_err(il_err),
        .il_count(il_count)
    );

    always #5 il_clk = ~il_clk;

    int checks = 0;
    int failures = 0;
    logic [7:0]  bq[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // every write must be the next word the model predicts
    always @(negedge il_clk) begin
        if (il_we === 1'b1) begin
            chk("ready_in_write", il_byte_ready, 0);
            if (exp_addr.size() == 0) chk("unexpected_we", 1, 0);
            else begin
                chk("waddr", il_waddr, exp_addr.pop_front());
                chk("wdata", il_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic start_load(input int len);
        @(posedge il_clk); #1;
        il_start = 1'b1;
        il_len   = LEN_W'(len);
        @(posedge il_clk); #1;
        il_start = 1'b0;
    endtask

    task automatic feed(input int nb, input int mode);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < nb && cyc < 4000) begin
            il_byte = bq[idx];
            il_byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom % 2);
            @(negedge il_clk);
            acc = il_byte_valid && il_byte_ready;
            @(posedge il_clk); #1;
            if (acc) idx++;
            cyc++;
        end
        il_byte_valid = 1'b0;
        if (idx < nb) chk("feed_timeout", idx, nb);
    endtask

    task automatic expect_words(input int words);
        for (int w = 0; w < words; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
        end
    endtask

    task automatic do_load(input int len, input int mode, input int abort_after, input bit bad_sum);
        int eff, nb, words;
        bit exp_err, cs_on;
        logic [7:0] x;
        eff = (len > DEPTH) ? DEPTH : len;
`ifdef ILOAD_CHECKSUM_EN
        cs_on = 1'b1;
`else
        cs_on = 1'b0;
`endif
        while (bq.size() < eff * 4 + 1) bq.push_back(8'($urandom));
        nb = eff * 4;
        words = (abort_after >= 0) ? abort_after / 4 : eff;
        if (abort_after >= 0) nb = abort_after;
        x = '0;
        for (int i = 0; i < eff * 4; i++) x ^= bq[i];
        exp_err = 1'b0;
        if (cs_on && abort_after < 0 && eff > 0) begin
            bq[eff*4] = bad_sum ? (x ^ 8'h01) : x;
            nb++;
            exp_err = bad_sum;
        end
        expect_words(words);
        start_load(len);
        feed(nb, mode);
        if (abort_after >= 0) begin
            il_abort = 1'b1;
            @(posedge il_clk); #1;
            il_abort = 1'b0;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge il_clk);
            if (!il_busy) break;
        end
        chk("busy_end", il_busy, 0);
        chk("done", il_done, abort_after < 0);
        chk("err", il_err, exp_err);
        chk("count", il_count, words);
        chk("pending_writes", exp_addr.size(), 0);
        @(negedge il_clk);
        chk("done_hold", il_done, abort_after < 0);
        bq.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        #1;
        chk("rst_we", il_we, 0);
        chk("rst_ready", il_byte_ready, 0);
        chk("rst_outs", {il_busy, il_done, il_err, il_count, il_waddr, il_wdata}, 0);
        repeat (2) @(posedge il_clk);
        #1 il_rst_n = 1'b1;

        // reset mid-load after 5 bytes: word 0 lands, then everything clears at once
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        expect_words(1);
        start_load(3);
        feed(5, 0);
        il_rst_n = 1'b0;
        #1;
        chk("midrst_we", il_we, 0);
        chk("midrst_ready", il_byte_ready, 0);
        chk("midrst_busy", il_busy, 0);
        chk("midrst_outs", {il_done, il_err, il_count, il_waddr, il_wdata}, 0);
        chk("midrst_pending", exp_addr.size(), 0);
        il_byte_valid = 1'b1;
        repeat (4) @(negedge il_clk);
        @(posedge il_clk); #1;
        il_byte_valid = 1'b0;
        il_rst_n = 1'b1;
        bq.delete();

        bq = '{8'h13, 8'h00, 8'h00, 8'h00};
        do_load(1, 0, -1, 1'b0);
        do_load(2, 1, -1, 1'b0);
        do_load(40, 0, -1, 1'b0);
        do_load(0, 0, -1, 1'b0);
        do_load(4, 0, 6, 1'b0);
        do_load(2, 2, -1, 1'b0);
`ifdef ILOAD_CHECKSUM_EN
        bq = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_load(1, 0, -1, 1'b0);
        bq = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_load(1, 0, -1, 1'b1);
`endif
        for (int t = 0; t < 10; t++) begin
            int len, ab;
            len = $urandom_range(0, 40);
            ab = ($urandom % 4 == 0 && len > 0) ? $urandom_range(1, ((len > DEPTH) ? DEPTH : len) * 4 - 1) : -1;
            if (ab >= 0 && ab % 4 == 0) ab++;
            do_load(len, $urandom_range(0, 2), ab, 1'($urandom % 2));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout obs=%0d exp=0", checks);
        $fatal(1, "timeout");
    end
endmodule
